rr_grant_encoder: RTL and testbench

Round-robin arbiter for 2^BITS requesters that emits the winner as a binary index with a valid/ready handshake, then tracks bus ownership until the owner releases. Its `grant_idx` output drives the `code_in` of the one-hot decoder stage directly downstream, which converts the index into per-requester enables. Fairness rotates from the last accepted owner, and an optional hold limit bounds how long one requester can keep the grant.

---
 rtl/rr_grant_if.sv | 20 ++
 rtl/rr_grant_encoder.sv | 93 +++++++++
 tb/tb_rr_grant_encoder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_if.sv
// rr_grant_if: request/grant handshake bundle between requesters and the round-robin grant encoder
interface rr_grant_if #(
    parameter int BITS = 3
);
    localparam int N = 1 << BITS;
    logic [N-1:0]    req;
    logic            grant_ready;
    logic            grant_valid;
    logic [BITS-1:0] grant_idx;
    logic            owned;
    logic            preempt;
    modport master (
        input  req, grant_ready,
        output grant_valid, grant_idx, owned, preempt
    );
    modport slave (
        output req, grant_ready,
        input  grant_valid, grant_idx, owned, preempt
    );
endinterface

// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin arbiter offering a binary winner index, tracking ownership with an optional hold limit
module rr_grant_encoder #(
    parameter int BITS     = 3,
    parameter int MAX_HOLD = 16
) (
    input logic        clk,
    input logic        rst_n,
    rr_grant_if.master bus
);
    localparam int N  = 1 << BITS;
    localparam int CW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {IDLE, OFFER, OWN} state_t;

    state_t          state, state_d;
    logic [BITS-1:0] ptr, ptr_d, idx_q, idx_d, win, k;
    logic [CW-1:0]   cnt, cnt_d;
    logic            pre_d, others;
    logic            valid_q, owned_q, preempt_q;

    assign others          = |(bus.req & ~(N'(1) << idx_q));
    assign bus.grant_valid = valid_q;
    assign bus.grant_idx   = idx_q;
    assign bus.owned       = owned_q;
    assign bus.preempt     = preempt_q;

    // first requester after ptr, scanning downwards so the nearest offset wins; ptr itself is last
    always_comb begin
        win = '0;
        k   = '0;
        for (int i = N; i >= 1; i--) begin
            k = ptr + BITS'(i);
            if (bus.req[k]) win = k;
        end
    end

    // next state: offer, accept, release and hold-limit preemption
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        idx_d   = idx_q;
        cnt_d   = cnt;
        pre_d   = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    idx_d   = win;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (!bus.req[idx_q]) state_d = IDLE;
                else if (bus.grant_ready) begin
                    state_d = OWN;
                    ptr_d   = idx_q;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                cnt_d = (cnt == HOLD_MAX) ? cnt : cnt + 1'b1;
                if (!bus.req[idx_q]) state_d = IDLE;
                else if (MAX_HOLD != 0 && cnt == HOLD_LAST && others) begin
                    pre_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs, cleared asynchronously so no grant survives reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '1;
            idx_q     <= '0;
            cnt       <= '0;
            valid_q   <= 1'b0;
            owned_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            idx_q     <= idx_d;
            cnt       <= cnt_d;
            valid_q   <= state_d == OFFER;
            owned_q   <= state_d == OWN;
            preempt_q <= pre_d;
        end
    end
endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: directed vectors with a queue-based scoreboard of expected offers and preemptions
module tb_rr_grant_encoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_grant_if #(.BITS(3)) bus();
    rr_grant_encoder #(.BITS(3), .MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic       pre;
        logic [2:0] idx;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic pre, input logic [2:0] idx);
        ev_t e;
        e.pre = pre;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input logic pre);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got idx %0d expected no event", pre ? "preempt" : "offer", bus.grant_idx);
        end else begin
            e = exp_q.pop_front();
            chk(pre ? "sb_preempt_kind" : "sb_offer_kind", int'(pre), int'(e.pre));
            chk(pre ? "sb_preempt_idx" : "sb_offer_idx", int'(bus.grant_idx), int'(e.idx));
        end
    endtask

    // monitor: every new offer and every preempt pulse is matched against the expected queue
    always @(negedge clk) begin
        if (bus.preempt) expect_ev(1'b1);
        if (bus.grant_valid && !prev_v) expect_ev(1'b0);
        prev_v = bus.grant_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int own, pc;
        rst_n = 1'b0;
        bus.req = 8'hFF;
        bus.grant_ready = 1'b0;
        repeat (3) tick;
        chk("rst_valid", bus.grant_valid, 0);
        chk("rst_idx", bus.grant_idx, 0);
        chk("rst_owned", bus.owned, 0);
        chk("rst_preempt", bus.preempt, 0);
        push(1'b0, 3'd0);
        rst_n = 1'b1;
        tick;
        chk("first_valid", bus.grant_valid, 1);
        chk("first_idx", bus.grant_idx, 0);

        bus.grant_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("rot_owned", bus.owned, 1);
            chk("rot_owner_idx", bus.grant_idx, k);
            bus.req[k] = 1'b0;
            tick;
            chk("rot_release", bus.owned, 0);
            bus.req[k] = 1'b1;
            push(1'b0, 3'((k + 1) % 8));
            tick;
        end
        bus.grant_ready = 1'b0;
        bus.req = 8'h00;
        tick;
        chk("withdraw_idle", bus.grant_valid, 0);

        bus.req = 8'h40;
        push(1'b0, 3'd6);
        tick;
        bus.grant_ready = 1'b1;
        tick;
        chk("own6", bus.owned, 1);
        bus.grant_ready = 1'b0;
        bus.req = 8'h05;
        tick;
        push(1'b0, 3'd0);
        tick;
        chk("wrap_idx", bus.grant_idx, 0);
        bus.grant_ready = 1'b1;
        tick;
        chk("own0", bus.owned, 1);
        bus.grant_ready = 1'b0;
        bus.req = 8'h04;
        tick;
        bus.req = 8'h05;
        push(1'b0, 3'd2);
        tick;
        chk("skip_idx", bus.grant_idx, 2);

        bus.req = 8'h00;
        tick;
        bus.req = 8'h08;
        push(1'b0, 3'd3);
        tick;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.req = 8'h28;
            tick;
            chk("bp_valid", bus.grant_valid, 1);
            chk("bp_idx", bus.grant_idx, 3);
        end
        bus.req = 8'h20;
        bus.grant_ready = 1'b1;
        tick;
        chk("wd_owned", bus.owned, 0);
        chk("wd_valid", bus.grant_valid, 0);
        push(1'b0, 3'd5);
        tick;
        chk("offer5_idx", bus.grant_idx, 5);
        chk("offer5_owned", bus.owned, 0);
        bus.grant_ready = 1'b0;
        bus.req = 8'h00;
        tick;

        bus.req = 8'h04;
        push(1'b0, 3'd2);
        tick;
        bus.req = 8'h44;
        bus.grant_ready = 1'b1;
        push(1'b1, 3'd2);
        push(1'b0, 3'd6);
        tick;
        bus.grant_ready = 1'b0;
        own = 0;
        pc = 0;
        for (int i = 0; i < 8; i++) begin
            own += int'(bus.owned);
            pc += int'(bus.preempt);
            tick;
        end
        chk("pre_own_cycles", own, 4);
        chk("pre_pulses", pc, 1);
        chk("pre_next_idx", bus.grant_idx, 6);
        chk("pre_next_valid", bus.grant_valid, 1);

        bus.req = 8'h00;
        tick;
        bus.req = 8'h04;
        push(1'b0, 3'd2);
        tick;
        bus.grant_ready = 1'b1;
        tick;
        bus.grant_ready = 1'b0;
        own = 0;
        pc = 0;
        for (int i = 0; i < 20; i++) begin
            own += int'(bus.owned);
            pc += int'(bus.preempt);
            tick;
        end
        chk("solo_own_cycles", own, 20);
        chk("solo_pulses", pc, 0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_owned", bus.owned, 0);
        chk("ar_valid", bus.grant_valid, 0);
        chk("ar_idx", bus.grant_idx, 0);
        bus.req = 8'h84;
        tick;
        tick;
        push(1'b0, 3'd2);
        rst_n = 1'b1;
        tick;
        chk("ar_next_idx", bus.grant_idx, 2);
        tick;
        tick;
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
